// File: rtl/bcd_pkg.sv
// Shared types and digit helpers for the digit-serial BCD adder/subtractor.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [BCD_W-1:0] nines_comp(input logic [BCD_W-1:0] digit);
    return BCD_MAX - digit;
  endfunction

  function automatic logic digit_invalid(input logic [BCD_W-1:0] digit);
    return (digit > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: binary add then +6 correction when the raw sum exceeds 9.
// Combinational, no latency, no flow control.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] w_raw;

  assign w_raw = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
  assign cout  = (w_raw > {1'b0, BCD_MAX});
  assign sum   = cout ? (w_raw[BCD_W-1:0] + 4'd6) : w_raw[BCD_W-1:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, LSD first, one digit per clock through one corrected adder.
// Latency DIGITS+1 cycles from input handshake; no overlap, result held until out_ready.
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_sub;
  logic               r_carry;
  logic               r_cout;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic [BCD_W-1:0]   w_a_dig;
  logic [BCD_W-1:0]   w_b_dig;
  logic [BCD_W-1:0]   w_b_eff;
  logic [BCD_W-1:0]   w_dig_sum;
  logic               w_dig_cout;
  logic               w_last;
  logic               w_capture;

  // Operands shift right each RUN cycle, so the active digit is always the low nibble.
  assign w_a_dig   = r_a[BCD_W-1:0];
  assign w_b_dig   = r_b[BCD_W-1:0];
  assign w_b_eff   = r_sub ? nines_comp(w_b_dig) : w_b_dig;
  assign w_last    = (r_cnt == CNT_W'(DIGITS - 1));
  assign w_capture = in_valid && (r_state == IDLE);

  bcd_digit_add u_digit_add (
    .a    (w_a_dig),
    .b    (w_b_eff),
    .cin  (r_carry),
    .sum  (w_dig_sum),
    .cout (w_dig_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_a     <= a;
      r_b     <= b;
      r_sub   <= sub;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == RUN) begin
      r_a                              <= r_a >> BCD_W;
      r_b                              <= r_b >> BCD_W;
      r_carry                          <= w_dig_cout;
      r_sum[int'(r_cnt)*BCD_W +: BCD_W] <= w_dig_sum;
      r_err                            <= r_err | digit_invalid(w_a_dig) | digit_invalid(w_b_dig);
      if (w_last) begin
        r_cout <= w_dig_cout;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // A bad operand digit poisons the whole result rather than exposing a meaningless sum.
  assign sum  = r_err ? '0 : r_sum;
  assign cout = r_cout & ~r_err;
  assign err  = r_err;

endmodule
